// File: rtl/plab5_mcore_dma_burst_engine.sv
// Multi-channel DMA copy engine: round-robin descriptor intake, per-domain
// security check, then a word-by-word read/write burst through one memory port.
module plab5_mcore_dma_burst_engine #(
  parameter int                      p_addr_nbits = 32,
  parameter int                      p_data_nbits = 32,
  parameter int                      p_len_nbits  = 8,
  parameter int                      p_num_chans  = 2,
  parameter logic [p_addr_nbits-1:0] p_sec_base   = 32'h8000_0000,
  localparam int                     C            = $clog2(p_num_chans)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [p_num_chans-1:0]              req_val,
  output logic [p_num_chans-1:0]              req_rdy,
  input  logic [p_num_chans*p_addr_nbits-1:0] req_src,
  input  logic [p_num_chans*p_addr_nbits-1:0] req_dst,
  input  logic [p_num_chans*p_len_nbits-1:0]  req_len,
  input  logic [p_num_chans-1:0]              req_domain,
  output logic                                done_val,
  output logic [C-1:0]                        done_chan,
  output logic                                done_err,
  output logic                                mem_req_val,
  input  logic                                mem_req_rdy,
  output logic [2:0]                          mem_req_type,
  output logic [p_addr_nbits-1:0]             mem_req_addr,
  output logic [p_data_nbits-1:0]             mem_req_data,
  output logic                                mem_req_domain,
  input  logic                                mem_resp_val,
  output logic                                mem_resp_rdy,
  input  logic [p_data_nbits-1:0]             mem_resp_data
);
  localparam int A      = p_addr_nbits;
  localparam int L      = p_len_nbits;
  localparam int STRIDE = p_data_nbits / 8;
  // End address is kept wide enough that dst + len*stride never wraps.
  localparam int EW     = A + L + 1;
  localparam logic [EW-1:0] ADDR_LIM = EW'(1) << A;

  typedef enum logic [2:0] {IDLE, CHECK, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [C-1:0]            last_grant, chan_r, gnt_idx;
  logic                    gnt_vld, dom_r, err_r, chk_err;
  logic [A-1:0]            src_r, dst_r;
  logic [L-1:0]            rem_r;
  logic [p_data_nbits-1:0] wbuf;
  logic [EW-1:0]           end_addr;
  int                      idx;

  // Highest-priority candidate is last_grant+1; later hits overwrite earlier ones.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = p_num_chans; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % p_num_chans;
      if (req_val[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = C'(idx);
      end
    end
  end

  assign end_addr = EW'(dst_r) + EW'(rem_r) * EW'(STRIDE);
  assign chk_err  = (!dom_r && rem_r != '0 && end_addr > EW'(p_sec_base))
                 || (end_addr > ADDR_LIM);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld)      state_nxt = CHECK;
      CHECK:   state_nxt = (chk_err || rem_r == '0) ? DONE : RD_REQ;
      RD_REQ:  if (mem_req_rdy)  state_nxt = RD_WAIT;
      RD_WAIT: if (mem_resp_val) state_nxt = WR_REQ;
      WR_REQ:  if (mem_req_rdy)  state_nxt = WR_WAIT;
      WR_WAIT: if (mem_resp_val) state_nxt = (rem_r == L'(1)) ? DONE : RD_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= C'(p_num_chans - 1);
      chan_r     <= '0;
      dom_r      <= 1'b0;
      err_r      <= 1'b0;
      src_r      <= '0;
      dst_r      <= '0;
      rem_r      <= '0;
      wbuf       <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          last_grant <= gnt_idx;
          chan_r     <= gnt_idx;
          src_r      <= req_src[gnt_idx*A +: A];
          dst_r      <= req_dst[gnt_idx*A +: A];
          rem_r      <= req_len[gnt_idx*L +: L];
          dom_r      <= req_domain[gnt_idx];
          err_r      <= 1'b0;
        end
        CHECK:   err_r <= chk_err;
        RD_WAIT: if (mem_resp_val) wbuf <= mem_resp_data;
        WR_WAIT: if (mem_resp_val) begin
          src_r <= src_r + A'(STRIDE);
          dst_r <= dst_r + A'(STRIDE);
          rem_r <= rem_r - L'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_rdy        = '0;
    done_val       = 1'b0;
    done_chan      = '0;
    done_err       = 1'b0;
    mem_req_val    = 1'b0;
    mem_req_type   = 3'd0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_domain = (state != IDLE) ? dom_r : 1'b0;
    mem_resp_rdy   = (state == RD_WAIT) || (state == WR_WAIT);
    case (state)
      IDLE:   if (gnt_vld) req_rdy[gnt_idx] = 1'b1;
      RD_REQ: begin
        mem_req_val  = 1'b1;
        mem_req_addr = src_r;
      end
      WR_REQ: begin
        mem_req_val  = 1'b1;
        mem_req_type = 3'd1;
        mem_req_addr = dst_r;
        mem_req_data = wbuf;
      end
      DONE: begin
        done_val  = 1'b1;
        done_chan = chan_r;
        done_err  = err_r;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_plab5_mcore_dma_burst_engine.sv
// Directed + randomized bench for the DMA burst engine, checked against a
// transaction-level copy model (expected read/write lists, grant order, latency).
module tb_plab5_mcore_dma_burst_engine;
  localparam int N = 2, A = 32, D = 32, L = 8, C = $clog2(N);
  localparam logic [31:0] SEC = 32'h8000_0000;

  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0]   req_val = '0, req_rdy, req_domain = '0;
  logic [N*A-1:0] req_src = '0, req_dst = '0;
  logic [N*L-1:0] req_len = '0;
  logic           done_val, done_err;
  logic [C-1:0]   done_chan;
  logic           mem_req_val, mem_req_rdy = 1'b0, mem_req_domain;
  logic [2:0]     mem_req_type;
  logic [A-1:0]   mem_req_addr;
  logic [D-1:0]   mem_req_data, mem_resp_data = '0;
  logic           mem_resp_val = 1'b0, mem_resp_rdy;

  plab5_mcore_dma_burst_engine #(.p_addr_nbits(A), .p_data_nbits(D), .p_len_nbits(L),
    .p_num_chans(N), .p_sec_base(SEC)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy), .req_src(req_src),
    .req_dst(req_dst), .req_len(req_len), .req_domain(req_domain), .done_val(done_val),
    .done_chan(done_chan), .done_err(done_err), .mem_req_val(mem_req_val),
    .mem_req_rdy(mem_req_rdy), .mem_req_type(mem_req_type), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_domain(mem_req_domain), .mem_resp_val(mem_resp_val),
    .mem_resp_rdy(mem_resp_rdy), .mem_resp_data(mem_resp_data));

  always #5 clk = ~clk;

  typedef struct {logic [2:0] typ; logic [31:0] addr; logic [31:0] data; logic dom;} mreq_t;
  typedef struct {int cyc; int chan;} acc_t;
  typedef struct {int cyc; int chan; logic err;} done_t;
  mreq_t mlog[$];
  acc_t  alog[$];
  done_t dlog[$];
  logic [31:0] mem [logic [31:0]];

  int cyc = 0, n_pass = 0, n_tot = 0, bp_cnt = 0, mdl_last = N - 1;
  bit rand_mode = 0, stray = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!reset) begin
    for (int i = 0; i < N; i++) if (req_val[i] && req_rdy[i]) alog.push_back('{cyc, i});
    if (done_val) dlog.push_back('{cyc, int'(done_chan), done_err});
  end

  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Memory: single outstanding request; response the cycle after the request
  // (random extra delay and random rdy in rand_mode).
  initial begin
    bit pend; int pdly; logic [31:0] pdata;
    pend = 0; pdly = 0; pdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_resp_val && mem_resp_rdy) pend = 0;
        if (mem_req_val && mem_req_rdy) begin
          mlog.push_back('{mem_req_type, mem_req_addr, mem_req_data, mem_req_domain});
          if (mem_req_type == 3'd1) begin mem[mem_req_addr] = mem_req_data; pdata = '0; end
          else pdata = mem_peek(mem_req_addr);
          pend = 1;
          pdly = rand_mode ? int'($urandom_range(0, 2)) : 0;
        end
      end
      @(posedge clk); #1;
      if (reset) pend = 0;
      if (pend && pdly > 0) begin pdly--; mem_resp_val = stray; end
      else mem_resp_val = pend | stray;
      mem_resp_data = pend ? pdata : $urandom;
      if (mem_req_val && mem_req_type == 3'd1 && bp_cnt > 0) begin mem_req_rdy = 1'b0; bp_cnt--; end
      else mem_req_rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic issue(input int ch, input logic [31:0] src, dst, input int len, input logic dom);
    bit ok; int a0;
    a0 = alog.size(); ok = 0;
    req_src[ch*A +: A] = src;
    req_dst[ch*A +: A] = dst;
    req_len[ch*L +: L] = L'(len);
    req_domain[ch]     = dom;
    req_val[ch]        = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin @(negedge clk); #1; ok = (alog.size() > a0); end
    chk("accepted", ok, 1);
    @(posedge clk); #1;
    req_val[ch] = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int n);
    bit ok; ok = 0;
    for (int k = 0; k < 600 && !ok; k++) begin @(negedge clk); #1; ok = (dlog.size() >= d0 + n); end
    chk("done_seen", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle_outs(input string tag);
    chk(tag, {req_rdy, done_val, done_chan, done_err, mem_req_val, mem_req_type, mem_req_addr,
              mem_req_data, mem_req_domain, mem_resp_rdy}, '0);
  endtask

  task automatic do_copy(input int ch, input logic [31:0] src, dst, input int len,
                         input logic dom, input int bp);
    longint e; logic err; logic [31:0] ed[$]; int a0, d0, nexp; bit ok;
    e    = longint'(dst) + longint'(len) * 4;
    err  = (!dom && len != 0 && e > longint'(SEC)) || (e > 64'h1_0000_0000);
    for (int i = 0; i < len && !err; i++) ed.push_back(mem_peek(src + 32'(4 * i)));
    nexp = err ? 0 : 2 * len;
    mlog.delete(); a0 = alog.size(); d0 = dlog.size(); bp_cnt = bp;
    issue(ch, src, dst, len, dom);
    if (alog.size() > a0) chk("grant_chan", alog[a0].chan, ch);
    if (bp > 0) begin
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
        @(negedge clk); #1; ok = mem_req_val && mem_req_type == 3'd1;
      end
      chk("bp_wr_seen", ok, 1);
      for (int k = 0; k < bp; k++) begin
        if (k > 0) begin @(negedge clk); #1; end
        chk($sformatf("bp_hold%0d", k), {mem_req_val, mem_req_type, mem_req_addr, mem_req_data,
            mem_req_domain}, {1'b1, 3'd1, dst, ed[0], dom});
      end
    end
    wait_done(d0, 1);
    if (dlog.size() > d0 && alog.size() > a0) begin
      chk("done_chan", dlog[d0].chan, ch);
      chk("done_err", dlog[d0].err, err);
      if (!rand_mode && bp == 0)
        chk("latency", dlog[d0].cyc - alog[a0].cyc, 2 + ((err || len == 0) ? 0 : 4 * len));
    end
    chk("mem_count", mlog.size(), nexp);
    for (int i = 0; i < nexp && i < mlog.size(); i++) begin
      if (i % 2 == 0)
        chk($sformatf("rd%0d", i / 2), {mlog[i].typ, mlog[i].addr, mlog[i].dom},
            {3'd0, src + 32'(4 * (i / 2)), dom});
      else
        chk($sformatf("wr%0d", i / 2), {mlog[i].typ, mlog[i].addr, mlog[i].data, mlog[i].dom},
            {3'd1, dst + 32'(4 * (i / 2)), ed[i / 2], dom});
    end
    idle_outs("idle_after");
    mdl_last = ch;
  endtask

  initial begin
    int a0, d0, m0;
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    idle_outs("reset_outs");
    reset = 1'b0;
    @(posedge clk); #1;

    // Single copy with known source data
    mem[32'h100] = 32'hA; mem[32'h104] = 32'hB; mem[32'h108] = 32'hC;
    do_copy(0, 32'h100, 32'h200, 3, 1'b1, 0);
    chk("dst_word2", mem[32'h208], 32'hC);

    // Security check and its boundaries
    do_copy(1, 32'h300, 32'h7FFF_FFF8, 3, 1'b0, 0);
    do_copy(1, 32'h300, 32'h7FFF_FFF8, 3, 1'b1, 0);
    do_copy(0, 32'h340, 32'h7FFF_FFF4, 3, 1'b0, 0);
    do_copy(1, 32'h380, 32'hFFFF_FFF8, 2, 1'b1, 0);
    do_copy(0, 32'h3C0, 32'hFFFF_FFFC, 2, 1'b1, 0);
    do_copy(0, 32'h400, 32'h480, 0, 1'b0, 0);

    // Write backpressure
    do_copy(1, 32'h500, 32'h580, 2, 1'b1, 5);

    // Round-robin with both channels requesting continuously
    a0 = alog.size(); d0 = dlog.size(); ok = 0;
    req_src = {32'h980, 32'h900}; req_dst = {32'hA80, 32'hA00};
    req_len = {8'd1, 8'd1}; req_domain = 2'b11; req_val = 2'b11;
    for (int k = 0; k < 200 && !ok; k++) begin @(negedge clk); #1; ok = (alog.size() >= a0 + 4); end
    @(posedge clk); #1;
    req_val = '0;
    wait_done(d0, 4);
    chk("rr_count", alog.size() - a0, 4);
    for (int j = 0; j < 4 && a0 + j < alog.size() && d0 + j < dlog.size(); j++) begin
      chk($sformatf("rr_grant%0d", j), alog[a0 + j].chan, (mdl_last + 1 + j) % N);
      chk($sformatf("rr_done%0d", j), dlog[d0 + j].chan, (mdl_last + 1 + j) % N);
    end
    mdl_last = (mdl_last + 4) % N;

    // Reset during RD_WAIT of a 4-word copy
    mlog.delete(); ok = 0;
    issue(0, 32'hB00, 32'hC00, 4, 1'b1);
    for (int k = 0; k < 50 && !ok; k++) begin @(negedge clk); #1; ok = (mlog.size() >= 3); end
    chk("rst_reach", ok, 1);
    @(negedge clk); #1;
    chk("rst_rdwait", {mem_resp_rdy, mem_req_val}, 2'b10);
    #1 reset = 1'b1;
    #1 idle_outs("rst_outs");
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    mdl_last = N - 1;
    @(posedge clk); #1;
    m0 = mlog.size(); d0 = dlog.size();
    stray = 1;
    repeat (3) begin @(posedge clk); #1; end
    stray = 0;
    @(posedge clk); #1;
    chk("stray_nowr", mlog.size(), m0);
    chk("stray_nodone", dlog.size(), d0);
    do_copy(0, 32'hD00, 32'hE00, 2, 1'b1, 0);

    // Randomized descriptors with random memory timing
    rand_mode = 1;
    for (int it = 0; it < 12; it++) begin
      int ch, len, sel; logic dom; logic [31:0] dst;
      ch  = $urandom_range(0, N - 1);
      len = $urandom_range(0, 5);
      dom = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 2);
      dst = (sel == 0) ? 32'h2000_0000 + 32'(it * 32'h100)
          : (sel == 1) ? SEC - 32'(4 * $urandom_range(0, 6))
          :              32'hFFFF_FFFC - 32'(4 * $urandom_range(0, 4));
      do_copy(ch, 32'h1000_0000 + 32'(it * 32'h100), dst, len, dom, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/plab5_mcore_dma_burst_engine.md
# plab5_mcore_dma_burst_engine

Multi-channel, parametrised DMA copy engine for the plab5 multicore memory system. It accepts copy descriptors (source, destination, word count, security domain) from `p_num_chans` requesters and arbitrates among them round-robin. Each granted descriptor runs as a word-by-word read-then-write burst through a single memory port, and every memory request is tagged with the descriptor's domain. Low-domain copies that would write into the high-security region are rejected before any memory traffic is issued.

## Interface
- `p_addr_nbits`, 32, byte address width
- `p_data_nbits`, 32, data word width; address stride per word is `p_data_nbits/8` bytes
- `p_len_nbits`, 8, word-count width; max burst is 2^p_len_nbits - 1 words
- `p_num_chans`, 2, number of descriptor channels, ≥2; channel index width is `c = $clog2(p_num_chans)`
- `p_sec_base`, 32'h8000_0000, first byte address of the high-security region
- `clk` in 1 — the only clock
- `reset` in 1 — asynchronous, active-high
- `req_val` in p_num_chans — per-channel descriptor valid
- `req_rdy` out p_num_chans — per-channel accept; at most one bit high
- `req_src` in p_num_chans*p_addr_nbits — flattened source addresses; channel i is at bits [i*a +: a]
- `req_dst` in p_num_chans*p_addr_nbits — flattened destination addresses
- `req_len` in p_num_chans*p_len_nbits — flattened word counts
- `req_domain` in p_num_chans — per-channel domain; 1 = high
- `done_val` out 1 — one-cycle completion pulse
- `done_chan` out c — channel that completed
- `done_err` out 1 — 1 = descriptor rejected by the security check
- `mem_req_val` out 1, `mem_req_rdy` in 1 — memory request handshake
- `mem_req_type` out 3 — 0 = read, 1 = write
- `mem_req_addr` out p_addr_nbits
- `mem_req_data` out p_data_nbits
- `mem_req_domain` out 1
- `mem_resp_val` in 1, `mem_resp_rdy` out 1 — memory response handshake
- `mem_resp_data` in p_data_nbits

## Operation
- States: IDLE, CHECK, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- **IDLE**
  - `req_rdy` is high only for the channel chosen by the round-robin pointer among channels with `req_val` high.
  - The search starts at `last_grant+1` and wraps modulo `p_num_chans`.
  - On handshake, latch src, dst, len, domain and the channel id into working registers, update `last_grant`, go to CHECK.
- **CHECK** (one cycle)
  - Compute `end = dst + len*(p_data_nbits/8)` at p_addr_nbits+p_len_nbits+1 bits, so there is no wrap.
  - err = `!domain && len != 0 && (end > p_sec_base)`.
  - Also set err when `end > 2^p_addr_nbits`, regardless of domain.
  - If err or len == 0, go to DONE. Otherwise go to RD_REQ.
- **RD_REQ**
  - `mem_req_val` = 1, type 0, addr = cur_src, domain = latched domain.
  - On `mem_req_rdy`, go to RD_WAIT.
- **RD_WAIT**
  - `mem_resp_rdy` = 1.
  - On `mem_resp_val`, capture data into the word buffer and go to WR_REQ.
- **WR_REQ**
  - `mem_req_val` = 1, type 1, addr = cur_dst, data = word buffer.
  - On `mem_req_rdy`, go to WR_WAIT.
- **WR_WAIT**
  - `mem_resp_rdy` = 1. On `mem_resp_val`:
    - advance cur_src and cur_dst by the stride, each modulo 2^p_addr_nbits;
    - decrement remaining;
    - if the new remaining is 0, go to DONE, else go to RD_REQ.
- **DONE**
  - `done_val` = 1 with `done_chan` and `done_err`, for exactly one cycle; then go to IDLE.
- `mem_req_domain` always equals the latched domain; it is 0 in IDLE.
- Outside the REQ states `mem_req_type`, `mem_req_addr` and `mem_req_data` are driven 0, never X.
- The memory port carries exactly one outstanding request at a time.

## Timing
- Reset value of every output is 0, state is IDLE and `last_grant` is `p_num_chans-1`, so channel 0 has first priority.
- Reset takes effect immediately, at any time, including mid-burst:
  - the working registers clear;
  - any later `mem_resp_val` is ignored, because `mem_resp_rdy` stays 0 in IDLE.
- Accept-to-first-read latency is 2 cycles: handshake at edge N, CHECK in N+1, `mem_req_val` in N+2.
- With zero-wait memory (rdy and resp the same cycle as the request), each word takes 4 cycles.
  - An L-word copy runs from the accept edge to the `done_val` cycle in 2 + 4L cycles.
  - A rejected or zero-length copy runs in 2 cycles.
- `req_rdy` is 0 in every state except IDLE. The next descriptor is accepted, at the earliest, in the cycle after DONE.
- Requests are held stable while `mem_req_val` is high and `mem_req_rdy` is low.

## Test plan
- **Single copy:** ch0 src 0x100, dst 0x200, len 3, domain 1; memory returns 0xA, 0xB, 0xC.
  - Expect reads at 0x100/0x104/0x108 and writes of 0xA/0xB/0xC at 0x200/0x204/0x208.
  - Expect `done_val` with chan 0, err 0 exactly 14 cycles after accept.
- **Security reject:** ch1 domain 0, dst 0x7FFF_FFF8, len 3.
  - Expect no `mem_req_val` and `done_err` = 1 two cycles after accept.
  - Repeating the same descriptor with domain 1 copies 3 words.
- **Round-robin:** both channels hold `req_val` continuously with len 1.
  - Expect the grant order 0, 1, 0, 1; no channel is granted twice while the other waits.
- **Zero length:** len 0 → no memory traffic, `done_val` with err 0 after 2 cycles.
- **Backpressure:** hold `mem_req_rdy` low for 5 cycles during WR_REQ.
  - Expect addr, data and domain stable throughout; the copy completes correctly afterwards.
- **Reset mid-burst:** assert `reset` during RD_WAIT of a 4-word copy.
  - All outputs are 0 immediately.
  - A stray `mem_resp_val` afterwards causes no write.
  - A new descriptor after reset copies correctly.
